// File: rtl/sigmoid_backprop_if.sv
// Handshake bundle for sigmoid_backprop: input side (y/grad_in), output side (grad_out)
// and the completed-transaction counter.
interface sigmoid_backprop_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] y;
    logic signed [DATA_W-1:0] grad_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] grad_out;
    logic [CNT_W-1:0]         txn_count;

    modport master (
        output in_valid, y, grad_in, out_ready,
        input  in_ready, out_valid, grad_out, txn_count
    );

    modport slave (
        input  in_valid, y, grad_in, out_ready,
        output in_ready, out_valid, grad_out, txn_count
    );
endinterface

// File: rtl/sigmoid_backprop.sv
// Sigmoid backward pass: grad_out = grad_in * y * (1 - y) in Q4.12,
// two-stage valid/ready pipeline with a completed-output counter.
module sigmoid_backprop #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 12,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    sigmoid_backprop_if.slave bp
);
    localparam int PROD_W = 2 * FRAC_W + 1;
    localparam int D_W    = FRAC_W - 1;
    localparam int P_W    = DATA_W + FRAC_W;
    localparam logic [FRAC_W:0]   ONE_Y   = (FRAC_W + 1)'(1) << FRAC_W;
    localparam logic [PROD_W-1:0] HALF_D  = PROD_W'(1) << (FRAC_W - 1);
    localparam logic [P_W-1:0]    HALF_P  = P_W'(1) << (FRAC_W - 1);
    localparam logic [DATA_W-2:0] ONE_CMP = (DATA_W - 1)'(1) << FRAC_W;

    logic                     s1_valid_q, s1_valid_d;
    logic [D_W-1:0]           s1_d_q, s1_d_d;
    logic signed [DATA_W-1:0] s1_grad_q, s1_grad_d;
    logic                     s2_valid_q, s2_valid_d;
    logic signed [DATA_W-1:0] s2_grad_q, s2_grad_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic                     s1_load, s2_load, consume, in_ready;
    logic [FRAC_W:0]          yc;
    logic [PROD_W-1:0]        dprod;
    logic signed [P_W-1:0]    p_rnd;

    // in_ready looks through both stages so a full pipe still streams when out_ready is high
    assign s2_load  = s1_valid_q & (~s2_valid_q | bp.out_ready);
    assign in_ready = ~s1_valid_q | s2_load;
    assign s1_load  = bp.in_valid & in_ready;
    assign consume  = s2_valid_q & bp.out_ready;

    always_comb begin
        yc = '0;
        if (bp.y[DATA_W-1]) begin
            yc = '0;
        end else if (bp.y[DATA_W-2:0] > ONE_CMP) begin
            yc = ONE_Y;
        end else begin
            yc = bp.y[FRAC_W:0];
        end
        dprod = PROD_W'(yc) * PROD_W'(ONE_Y - yc) + HALF_D;
        p_rnd = P_W'(s1_grad_q) * P_W'($signed({1'b0, s1_d_q})) + $signed(HALF_P);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d_d     = s1_d_q;
        s1_grad_d  = s1_grad_q;
        s2_valid_d = s2_valid_q;
        s2_grad_d  = s2_grad_q;
        cnt_d      = cnt_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_d_d     = dprod[2*FRAC_W-2:FRAC_W];
            s1_grad_d  = bp.grad_in;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        // The arithmetic shift then truncation reduces to a slice of the rounded product
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_grad_d  = p_rnd[FRAC_W +: DATA_W];
        end else if (consume) begin
            s2_valid_d = 1'b0;
        end

        if (consume) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_d_q     <= '0;
            s1_grad_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_grad_q  <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_d_q     <= s1_d_d;
            s1_grad_q  <= s1_grad_d;
            s2_valid_q <= s2_valid_d;
            s2_grad_q  <= s2_grad_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bp.in_ready  = in_ready;
    assign bp.out_valid = s2_valid_q;
    assign bp.grad_out  = s2_grad_q;
    assign bp.txn_count = cnt_q;
endmodule

// File: tb/tb_sigmoid_backprop.sv
// Directed self-checking bench for sigmoid_backprop; a second instance with a 4-bit
// counter exercises the counter wrap.
module tb_sigmoid_backprop;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sigmoid_backprop_if #(.DATA_W(16), .CNT_W(16)) bp ();
    sigmoid_backprop_if #(.DATA_W(16), .CNT_W(4))  bw ();

    sigmoid_backprop #(.DATA_W(16), .FRAC_W(12), .CNT_W(16)) u_dut  (.clk(clk), .rst(rst), .bp(bp));
    sigmoid_backprop #(.DATA_W(16), .FRAC_W(12), .CNT_W(4))  u_wrap (.clk(clk), .rst(rst), .bp(bw));

    logic [15:0] tv_y [11] = '{16'h0C00, 16'h0001, 16'h0000, 16'h1000, 16'hF000, 16'h1800,
                               16'h0800, 16'h0800, 16'h07FF, 16'h0800, 16'h0800};
    logic [15:0] tv_g [11] = '{16'hF000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                               16'h0002, 16'hFFFE, 16'h1000, 16'h8000, 16'h0001};
    logic [15:0] tv_e [11] = '{16'hFD00, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                               16'h0001, 16'h0000, 16'h0400, 16'hE000, 16'h0000};

    logic [15:0] bb_y [8] = '{16'h0800, 16'h0400, 16'h0400, 16'h0800,
                              16'h0800, 16'h0800, 16'h0800, 16'h0800};
    logic [15:0] bb_g [8] = '{16'h0800, 16'h1000, 16'hF000, 16'hF000,
                              16'h7FFF, 16'h8000, 16'h0002, 16'hFFFE};
    logic [15:0] bb_e [8] = '{16'h0200, 16'h0300, 16'hFD00, 16'hFC00,
                              16'h2000, 16'hE000, 16'h0001, 16'h0000};

    logic [15:0] st_y [4] = '{16'h0800, 16'h0C00, 16'h0400, 16'h0001};
    logic [15:0] st_g [4] = '{16'h1000, 16'hF000, 16'h1000, 16'h7FFF};
    logic [15:0] st_e [4] = '{16'h0400, 16'hFD00, 16'h0300, 16'h0008};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bp.in_valid = 1'b0; bp.y = '0; bp.grad_in = '0; bp.out_ready = 1'b0;
        bw.in_valid = 1'b0; bw.y = '0; bw.grad_in = '0; bw.out_ready = 1'b0;
        rst = 1'b1;
        step; step;
        rst = 1'b0;
        #1;
        total++; if (bp.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bp.out_valid); end
        total++; if (bp.grad_out !== 16'h0000) begin bad++; $display("FAIL reset_grad_out got=%h exp=0000", bp.grad_out); end
        total++; if (bp.txn_count !== 16'h0000) begin bad++; $display("FAIL reset_txn got=%0d exp=0", bp.txn_count); end
        total++; if (bp.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bp.in_ready); end
        total++; if (bw.txn_count !== 4'h0) begin bad++; $display("FAIL reset_wrap_txn got=%0d exp=0", bw.txn_count); end
    endtask

    task automatic test_basic;
        bp.out_ready = 1'b1;
        bp.in_valid = 1'b1; bp.y = 16'h0800; bp.grad_in = 16'h1000;
        #1;
        total++; if (bp.in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b exp=1", bp.in_ready); end
        step;
        bp.in_valid = 1'b0;
        #1;
        total++; if (bp.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", bp.out_valid); end
        step;
        total++; if (bp.out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b exp=1", bp.out_valid); end
        total++; if (bp.grad_out !== 16'h0400) begin bad++; $display("FAIL basic_grad got=%h exp=0400", bp.grad_out); end
        step;
        total++; if (bp.txn_count !== 16'd1) begin bad++; $display("FAIL basic_txn got=%0d exp=1", bp.txn_count); end
        total++; if (bp.out_valid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%b exp=0", bp.out_valid); end
    endtask

    task automatic test_values;
        int n;
        bp.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bp.in_valid = 1'b1; bp.y = tv_y[i]; bp.grad_in = tv_g[i];
            step;
            bp.in_valid = 1'b0;
            n = 0;
            while (!bp.out_valid && n < 5) begin step; n++; end
            total++;
            if (!bp.out_valid) begin
                bad++; $display("FAIL value_timeout idx=%0d got=no_output exp=%h", i, tv_e[i]);
            end else if (bp.grad_out !== tv_e[i]) begin
                bad++; $display("FAIL value idx=%0d y=%h g=%h got=%h exp=%h", i, tv_y[i], tv_g[i], bp.grad_out, tv_e[i]);
            end
            step;
        end
    endtask

    task automatic test_back_to_back;
        int in_idx = 0;
        int out_idx = 0;
        int first = -1;
        bp.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (in_idx < 8) begin
                bp.in_valid = 1'b1; bp.y = bb_y[in_idx]; bp.grad_in = bb_g[in_idx];
            end else begin
                bp.in_valid = 1'b0;
            end
            #1;
            if (bp.in_valid) begin
                total++; if (bp.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cycle=%0d got=%b exp=1", c, bp.in_ready); end
            end
            if (bp.out_valid) begin
                total++;
                if (out_idx >= 8) begin
                    bad++; $display("FAIL b2b_extra cycle=%0d got=%h exp=none", c, bp.grad_out);
                end else begin
                    if (bp.grad_out !== bb_e[out_idx]) begin
                        bad++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", out_idx, bp.grad_out, bb_e[out_idx]);
                    end
                    if (out_idx == 0) first = c;
                    else if (c != first + out_idx) begin
                        bad++; $display("FAIL b2b_gap idx=%0d got_cycle=%0d exp_cycle=%0d", out_idx, c, first + out_idx);
                    end
                end
                out_idx++;
            end
            if (bp.in_valid && bp.in_ready) in_idx++;
            step;
        end
        total++; if (out_idx != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", out_idx); end
    endtask

    task automatic test_stall;
        int in_idx = 0;
        int out_idx = 0;
        bp.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bp.in_valid = 1'b1; bp.y = st_y[in_idx]; bp.grad_in = st_g[in_idx];
            #1;
            if (bp.out_valid) begin
                total++; if (bp.grad_out !== st_e[0]) begin bad++; $display("FAIL stall_hold cycle=%0d got=%h exp=%h", c, bp.grad_out, st_e[0]); end
            end
            if (bp.in_ready) in_idx++;
            step;
        end
        total++; if (in_idx != 2) begin bad++; $display("FAIL stall_accepted got=%0d exp=2", in_idx); end
        total++; if (bp.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", bp.in_ready); end
        total++; if (bp.out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid got=%b exp=1", bp.out_valid); end
        bp.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (in_idx < 4) begin
                bp.in_valid = 1'b1; bp.y = st_y[in_idx]; bp.grad_in = st_g[in_idx];
            end else begin
                bp.in_valid = 1'b0;
            end
            #1;
            if (bp.out_valid) begin
                total++;
                if (out_idx >= 4) begin
                    bad++; $display("FAIL stall_extra got=%h exp=none", bp.grad_out);
                end else if (bp.grad_out !== st_e[out_idx]) begin
                    bad++; $display("FAIL stall_order idx=%0d got=%h exp=%h", out_idx, bp.grad_out, st_e[out_idx]);
                end
                out_idx++;
            end
            if (bp.in_valid && bp.in_ready) in_idx++;
            step;
        end
        total++; if (out_idx != 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", out_idx); end
    endtask

    task automatic test_reset_midstall;
        logic leaked = 1'b0;
        bp.out_ready = 1'b0;
        bp.in_valid = 1'b1; bp.y = 16'h0800; bp.grad_in = 16'h1000;
        step; step; step;
        bp.in_valid = 1'b0;
        #1;
        total++; if (bp.in_ready !== 1'b0) begin bad++; $display("FAIL midstall_full got_in_ready=%b exp=0", bp.in_ready); end
        total++; if (bp.txn_count === 16'd0) begin bad++; $display("FAIL midstall_precount got=%0d exp=nonzero", bp.txn_count); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        #1;
        total++; if (bp.out_valid !== 1'b0) begin bad++; $display("FAIL midstall_out_valid got=%b exp=0", bp.out_valid); end
        total++; if (bp.grad_out !== 16'h0000) begin bad++; $display("FAIL midstall_grad got=%h exp=0000", bp.grad_out); end
        total++; if (bp.txn_count !== 16'd0) begin bad++; $display("FAIL midstall_txn got=%0d exp=0", bp.txn_count); end
        total++; if (bp.in_ready !== 1'b1) begin bad++; $display("FAIL midstall_in_ready got=%b exp=1", bp.in_ready); end
        bp.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step;
            if (bp.out_valid) leaked = 1'b1;
        end
        total++; if (leaked !== 1'b0) begin bad++; $display("FAIL midstall_discard got=%b exp=0", leaked); end
    endtask

    task automatic test_wrap;
        int sent = 0;
        bw.out_ready = 1'b1; bw.y = 16'h0800; bw.grad_in = 16'h1000;
        for (int c = 0; c < 40; c++) begin
            bw.in_valid = (sent < 15);
            #1;
            if (bw.in_valid && bw.in_ready) sent++;
            step;
        end
        bw.in_valid = 1'b0;
        total++; if (bw.txn_count !== 4'hF) begin bad++; $display("FAIL wrap_preload got=%0d exp=15", bw.txn_count); end
        bw.in_valid = 1'b1;
        step;
        bw.in_valid = 1'b0;
        step; step; step;
        total++; if (bw.txn_count !== 4'h0) begin bad++; $display("FAIL wrap_rollover got=%0d exp=0", bw.txn_count); end
        total++; if (bw.out_valid !== 1'b0) begin bad++; $display("FAIL wrap_drained got=%b exp=0", bw.out_valid); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_values;
        test_back_to_back;
        test_stall;
        test_reset_midstall;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
